decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Registered successor to the combinational decode stage: a parametrised decode stage with its own ID/EX pipeline register.
- Contains a 2-read/1-write register file.
- Resolves branches and jumps in decode, issuing a one-cycle fetch redirect and squashing one wrong-path instruction.
- Detects load-use hazards and stalls fetch.
- Sits between fetch (valid/ready upstream) and execute (valid/ready downstream).

Parameters:
XLEN, 32, data/PC width
REG_COUNT, 32, architectural registers; RW = clog2(REG_COUNT)
RESET_VAL, 0, reset value of every register-file entry except x0

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
i_valid  in  1  fetch presents instruction
o_ready  out  1  decode accepts instruction this cycle
i_inst  in  32  instruction word
i_pc  in  XLEN  instruction PC
i_wb_en  in  1  write-back enable
i_wb_rd_num  in  RW  write-back register
i_wb_rd  in  XLEN  write-back data
i_ex_load  in  1  instruction in EX is a load
i_ex_rd_num  in  RW  destination of instruction in EX
i_ex_ready  in  1  execute accepts o_valid data
o_valid  out  1  decoded bundle valid
o_pc, o_rs_1, o_rs_2  out  XLEN  PC and operand values
o_rd_num  out  RW  destination register
o_opcode, o_func_7  out  7  instruction fields
o_func_3  out  3  instruction field
o_imm  out  XLEN  sign-extended immediate, selected by format
o_b_taken  out  1  one-cycle fetch redirect
o_b_pc  out  XLEN  redirect target

Behaviour:
- Reset (i_rst=0, async): all outputs 0, FSM=RUN, register file=RESET_VAL, x0=0.
- Register file: writes at posedge when i_wb_en=1 and i_wb_rd_num!=0. Reads are combinational. x0 always reads 0.
- hazard = i_valid & i_ex_load & i_ex_rd_num!=0 & (i_ex_rd_num==inst[19:15] | i_ex_rd_num==inst[24:20]).
- RUN: o_ready = (~o_valid | i_ex_ready) & ~hazard. fire = i_valid & o_ready.
- On fire: register all fields, operands and o_imm. o_valid<=1.
- With i_ex_ready=1 and no fire: o_valid<=0.
- With o_valid=1 and i_ex_ready=0: hold every output stable.
- Immediate formats (sign-extended to XLEN):
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011 (LSB 0)
  - U: 0110111, 0010111 (imm<<12)
  - J: 1101111 (LSB 0)
  - any other opcode: 0
- Branch resolution on fire:
  - B-type: compare rs_1/rs_2 per func_3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU); other func_3 is not taken.
  - Branch target: pc+imm.
  - JAL: always taken, target pc+imm.
  - JALR: always taken, target (rs_1+imm)&~1.
  - Taken: o_b_taken<=1 and o_b_pc<=target for exactly one cycle; FSM->SQUASH.
  - Not taken: o_b_taken<=0.
- SQUASH:
  - o_ready = ~o_valid | i_ex_ready; hazard is ignored.
  - The first fire is discarded: o_valid gets no new data (it follows the RUN drain rule), no branch is evaluated, FSM->RUN.
  - Reset during SQUASH returns to RUN with nothing pending.
- Addition wraps modulo 2^XLEN. Stall and squash never drop an accepted valid instruction.

Optional Feature:
Macro DECODE_WB_BYPASS_EN.
- Defined: a same-cycle write-back whose i_wb_rd_num matches a nonzero source register forwards i_wb_rd to that operand.
- Undefined: no bypass. hazard is additionally asserted when i_wb_en=1, i_wb_rd_num!=0 and it matches a source, giving a one-cycle stall. The written value is then read from the register file.

Decomposition:
- constants.vh holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_IMM)
  - func_3 branch codes
  - default XLEN
  - FSM state encodings RUN/SQUASH
- One sub-module: reg_file_2r1w (parametrised XLEN/REG_COUNT, async reset, optional bypass).

Test Plan:
- Reset mid-stream, then release -> all outputs 0, o_ready=1 with i_ex_ready=1, x5 reads 0.
- WB x5=0x1234, then ADDI x6,x5,1 (0x00128313) at pc 0x100 -> next cycle o_valid=1, o_rs_1=0x1234, o_imm=1, o_rd_num=6.
- i_ex_load=1, i_ex_rd_num=5, then ADD x7,x5,x1 -> o_ready=0 for 1 cycle; accepted when i_ex_load drops.
- BEQ x0,x0,+16 at pc 0x200 -> o_b_taken=1 one cycle, o_b_pc=0x210; next fetched inst discarded, o_valid=0 for it.
- JALR x1,8(x2) with x2=0x303 -> o_b_pc=0x30A; i_ex_ready=0 for 3 cycles holds the bundle unchanged.
- Same-cycle WB x3=0xAA and decode of ADD using x3 -> with DECODE_WB_BYPASS_EN, o_rs_1=0xAA with no stall; without it, 1-cycle stall then 0xAA.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared constants, instruction field layout and immediate generator for decode_stage_pipe.
package decode_stage_pipe_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned INST_W       = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  typedef struct packed {
    logic [6:0] func_7;
    logic [4:0] rs_2;
    logic [4:0] rs_1;
    logic [2:0] func_3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_t;

  // 32-bit sign-extended immediate; the caller widens to XLEN
  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'b0};
      OP_JAL:                   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch/write-back/execute facing signals of decode_stage_pipe; slave = decode stage side.
interface decode_stage_pipe_if
  import decode_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN,
  parameter int unsigned RW   = 5
);
  logic              i_valid;
  logic              o_ready;
  logic [INST_W-1:0] i_inst;
  logic [XLEN-1:0]   i_pc;
  logic              i_wb_en;
  logic [RW-1:0]     i_wb_rd_num;
  logic [XLEN-1:0]   i_wb_rd;
  logic              i_ex_load;
  logic [RW-1:0]     i_ex_rd_num;
  logic              i_ex_ready;
  logic              o_valid;
  logic [XLEN-1:0]   o_pc;
  logic [XLEN-1:0]   o_rs_1;
  logic [XLEN-1:0]   o_rs_2;
  logic [RW-1:0]     o_rd_num;
  logic [6:0]        o_opcode;
  logic [6:0]        o_func_7;
  logic [2:0]        o_func_3;
  logic [XLEN-1:0]   o_imm;
  logic              o_b_taken;
  logic [XLEN-1:0]   o_b_pc;

  modport slave (
    input  i_valid, i_inst, i_pc, i_wb_en, i_wb_rd_num, i_wb_rd,
           i_ex_load, i_ex_rd_num, i_ex_ready,
    output o_ready, o_valid, o_pc, o_rs_1, o_rs_2, o_rd_num, o_opcode,
           o_func_7, o_func_3, o_imm, o_b_taken, o_b_pc
  );

  modport master (
    output i_valid, i_inst, i_pc, i_wb_en, i_wb_rd_num, i_wb_rd,
           i_ex_load, i_ex_rd_num, i_ex_ready,
    input  o_ready, o_valid, o_pc, o_rs_1, o_rs_2, o_rd_num, o_opcode,
           o_func_7, o_func_3, o_imm, o_b_taken, o_b_pc
  );
endinterface

// File: rtl/decode_stage_pipe_reg_file_2r1w.sv
// 2-read/1-write register file, x0 hard-wired to zero, optional same-cycle write bypass.
module reg_file_2r1w #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       REG_COUNT = 32,
  parameter logic [XLEN-1:0]   RESET_VAL = '0,
  parameter bit                BYPASS    = 1'b0,
  localparam int unsigned      RW        = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RW-1:0]   wr_num,
  input  logic [XLEN-1:0] wr_data,
  input  logic [RW-1:0]   rd_num_1,
  input  logic [RW-1:0]   rd_num_2,
  output logic [XLEN-1:0] rd_data_1_c,
  output logic [XLEN-1:0] rd_data_2_c
);

  logic [XLEN-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (we && wr_num != '0) begin
      regs[wr_num] <= wr_data;
    end
  end

  // Read ports: bypass (when built in) wins over storage, x0 wins over both
  always_comb begin
    rd_data_1_c = regs[rd_num_1];
    if (BYPASS && we && wr_num == rd_num_1) rd_data_1_c = wr_data;
    if (rd_num_1 == '0) rd_data_1_c = '0;
  end

  always_comb begin
    rd_data_2_c = regs[rd_num_2];
    if (BYPASS && we && wr_num == rd_num_2) rd_data_2_c = wr_data;
    if (rd_num_2 == '0) rd_data_2_c = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage with ID/EX register, branch resolution and load-use stall.
// Build option: DECODE_WB_BYPASS_EN forwards same-cycle write-back instead of stalling.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int unsigned     XLEN      = DEFAULT_XLEN,
  parameter int unsigned     REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  decode_stage_pipe_if.slave  bus
);

  localparam int unsigned RW = $clog2(REG_COUNT);

`ifdef DECODE_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  state_t          state;
  inst_t           inst;
  logic [RW-1:0]   rs_1_num;
  logic [RW-1:0]   rs_2_num;
  logic [XLEN-1:0] rs_1_val_c;
  logic [XLEN-1:0] rs_2_val_c;
  logic [XLEN-1:0] imm_c;
  logic            hazard_c;
  logic            ready_c;
  logic            fire_c;
  logic            taken_c;
  logic [XLEN-1:0] target_c;

  assign inst     = inst_t'(bus.i_inst);
  assign rs_1_num = RW'(inst.rs_1);
  assign rs_2_num = RW'(inst.rs_2);
  assign imm_c    = XLEN'($signed(imm_gen(bus.i_inst)));

  reg_file_2r1w #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .RESET_VAL (RESET_VAL),
    .BYPASS    (WB_BYPASS)
  ) u_reg_file (
    .clk         (i_clk),
    .rst_n       (i_rst),
    .we          (bus.i_wb_en),
    .wr_num      (bus.i_wb_rd_num),
    .wr_data     (bus.i_wb_rd),
    .rd_num_1    (rs_1_num),
    .rd_num_2    (rs_2_num),
    .rd_data_1_c (rs_1_val_c),
    .rd_data_2_c (rs_2_val_c)
  );

  // Stall on load-use; without bypass also wait one cycle for a write-back into a source
  always_comb begin
    logic ex_match;
    logic wb_match;
    ex_match = bus.i_ex_rd_num != '0 &&
               (bus.i_ex_rd_num == rs_1_num || bus.i_ex_rd_num == rs_2_num);
    wb_match = bus.i_wb_rd_num != '0 &&
               (bus.i_wb_rd_num == rs_1_num || bus.i_wb_rd_num == rs_2_num);
    hazard_c = bus.i_valid &&
               ((bus.i_ex_load && ex_match) || (!WB_BYPASS && bus.i_wb_en && wb_match));
    ready_c  = (!bus.o_valid || bus.i_ex_ready) && (state == ST_SQUASH || !hazard_c);
    fire_c   = bus.i_valid && ready_c;
  end

  assign bus.o_ready = ready_c;

  always_comb begin
    taken_c  = 1'b0;
    target_c = bus.i_pc + imm_c;
    case (inst.opcode)
      OP_BRANCH: begin
        case (inst.func_3)
          F3_BEQ:  taken_c = rs_1_val_c == rs_2_val_c;
          F3_BNE:  taken_c = rs_1_val_c != rs_2_val_c;
          F3_BLT:  taken_c = $signed(rs_1_val_c) <  $signed(rs_2_val_c);
          F3_BGE:  taken_c = $signed(rs_1_val_c) >= $signed(rs_2_val_c);
          F3_BLTU: taken_c = rs_1_val_c <  rs_2_val_c;
          F3_BGEU: taken_c = rs_1_val_c >= rs_2_val_c;
          default: taken_c = 1'b0;
        endcase
      end
      OP_JAL:  taken_c = 1'b1;
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = (rs_1_val_c + imm_c) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: taken_c = 1'b0;
    endcase
  end

  // ID/EX register; in SQUASH the first accepted instruction is dropped
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_RUN;
      bus.o_valid   <= 1'b0;
      bus.o_pc      <= '0;
      bus.o_rs_1    <= '0;
      bus.o_rs_2    <= '0;
      bus.o_rd_num  <= '0;
      bus.o_opcode  <= '0;
      bus.o_func_7  <= '0;
      bus.o_func_3  <= '0;
      bus.o_imm     <= '0;
      bus.o_b_taken <= 1'b0;
      bus.o_b_pc    <= '0;
    end else begin
      bus.o_b_taken <= 1'b0;
      if (fire_c && state == ST_RUN) begin
        bus.o_valid  <= 1'b1;
        bus.o_pc     <= bus.i_pc;
        bus.o_rs_1   <= rs_1_val_c;
        bus.o_rs_2   <= rs_2_val_c;
        bus.o_rd_num <= RW'(inst.rd);
        bus.o_opcode <= inst.opcode;
        bus.o_func_7 <= inst.func_7;
        bus.o_func_3 <= inst.func_3;
        bus.o_imm    <= imm_c;
        if (taken_c) begin
          bus.o_b_taken <= 1'b1;
          bus.o_b_pc    <= target_c;
          state         <= ST_SQUASH;
        end
      end else begin
        if (fire_c) state <= ST_RUN;
        if (bus.i_ex_ready) bus.o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed vector table, corner sequences and random run vs a reference model.
module tb_decode_stage_pipe;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned RW        = 5;
  localparam logic [XLEN-1:0] RESET_VAL = '0;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_pipe_if #(.XLEN(XLEN), .RW(RW)) bus ();

  decode_stage_pipe #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .RESET_VAL(RESET_VAL)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        ex_ready;
  } in_t;

  typedef struct {
    in_t         c;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_rs1;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_bt;
    logic [31:0] e_bpc;
  } vec_t;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_valid, m_squash, m_bt;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_bpc;
  logic [4:0]  m_rd;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                             input logic we, input logic [4:0] wr, input logic [31:0] wd,
                             input logic ld, input logic [4:0] er, input logic er_rdy);
    in_t c;
    c.valid = v; c.inst = inst; c.pc = pc; c.wb_en = we; c.wb_rd = wr; c.wb_d = wd;
    c.ex_load = ld; c.ex_rd = er; c.ex_ready = er_rdy;
    return c;
  endfunction

  // Immediate by field arithmetic: sign extension as subtracting 2^width when the sign bit is set
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    logic [31:0] v;
    v = 32'h0;
    case (x[6:0])
      7'h13, 7'h03, 7'h67: begin v = x >> 20; if (x[31]) v -= 32'h1000; end
      7'h23: begin v = ((x >> 25) << 5) | ((x >> 7) & 32'h1F); if (x[31]) v -= 32'h1000; end
      7'h63: begin
        v = ((x >> 31) << 12) | (((x >> 7) & 32'h1) << 11) | (((x >> 25) & 32'h3F) << 5)
          | (((x >> 8) & 32'hF) << 1);
        if (x[31]) v -= 32'h2000;
      end
      7'h37, 7'h17: v = (x >> 12) << 12;
      7'h6F: begin
        v = ((x >> 31) << 20) | (((x >> 12) & 32'hFF) << 12) | (((x >> 20) & 32'h1) << 11)
          | (((x >> 21) & 32'h3FF) << 1);
        if (x[31]) v -= 32'h200000;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rval(input logic [4:0] n, input in_t c);
    if (n == 0) return 32'h0;
    if (BYP && c.wb_en && c.wb_rd == n) return c.wb_d;
    return m_regs[n];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 32'h0 : RESET_VAL;
    m_valid = 0; m_squash = 0; m_bt = 0;
    m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_bpc = 0; m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
  endtask

  task automatic model_comb(input in_t c, output bit rdy, output bit fire);
    logic [4:0] a, b;
    bit h;
    a = c.inst[19:15];
    b = c.inst[24:20];
    h = c.valid && ((c.ex_load && c.ex_rd != 0 && (c.ex_rd == a || c.ex_rd == b)) ||
                    (!BYP && c.wb_en && c.wb_rd != 0 && (c.wb_rd == a || c.wb_rd == b)));
    rdy  = (!m_valid || c.ex_ready) && (m_squash || !h);
    fire = c.valid && rdy;
  endtask

  task automatic model_edge(input in_t c, input bit fire);
    logic [31:0] s1, s2, tgt;
    bit tk;
    m_bt = 0;
    if (fire && !m_squash) begin
      s1 = rval(c.inst[19:15], c);
      s2 = rval(c.inst[24:20], c);
      m_valid = 1; m_pc = c.pc; m_rs1 = s1; m_rs2 = s2; m_imm = ref_imm(c.inst);
      m_rd = c.inst[11:7]; m_op = c.inst[6:0]; m_f3 = c.inst[14:12]; m_f7 = c.inst[31:25];
      tk = 0;
      tgt = c.pc + m_imm;
      if (m_op == 7'h63) begin
        case (m_f3)
          3'd0: tk = s1 == s2;
          3'd1: tk = s1 != s2;
          3'd4: tk = (s1 ^ 32'h80000000) <  (s2 ^ 32'h80000000);
          3'd5: tk = (s1 ^ 32'h80000000) >= (s2 ^ 32'h80000000);
          3'd6: tk = s1 <  s2;
          3'd7: tk = s1 >= s2;
          default: tk = 0;
        endcase
      end else if (m_op == 7'h6F) begin
        tk = 1;
      end else if (m_op == 7'h67) begin
        tk = 1;
        tgt = (s1 + m_imm) & 32'hFFFFFFFE;
      end
      if (tk) begin m_bt = 1; m_bpc = tgt; m_squash = 1; end
    end else begin
      if (fire) m_squash = 0;
      if (c.ex_ready) m_valid = 0;
    end
    if (c.wb_en && c.wb_rd != 0) m_regs[c.wb_rd] = c.wb_d;
  endtask

  task automatic drive(input in_t c);
    bus.i_valid = c.valid; bus.i_inst = c.inst; bus.i_pc = c.pc;
    bus.i_wb_en = c.wb_en; bus.i_wb_rd_num = c.wb_rd; bus.i_wb_rd = c.wb_d;
    bus.i_ex_load = c.ex_load; bus.i_ex_rd_num = c.ex_rd; bus.i_ex_ready = c.ex_ready;
  endtask

  task automatic check_outputs();
    chk("valid", bus.o_valid, m_valid);
    chk("b_taken", bus.o_b_taken, m_bt);
    if (m_valid) begin
      chk("pc", bus.o_pc, m_pc);
      chk("rs_1", bus.o_rs_1, m_rs1);
      chk("rs_2", bus.o_rs_2, m_rs2);
      chk("rd_num", bus.o_rd_num, m_rd);
      chk("opcode", bus.o_opcode, m_op);
      chk("func_3", bus.o_func_3, m_f3);
      chk("func_7", bus.o_func_7, m_f7);
      chk("imm", bus.o_imm, m_imm);
    end
    if (m_bt) chk("b_pc", bus.o_b_pc, m_bpc);
  endtask

  // One clock: drive, check o_ready before the edge, advance model, check registered outputs
  task automatic cycle(input in_t c, output logic rdy_seen);
    bit rdy, fire;
    drive(c);
    #1;
    model_comb(c, rdy, fire);
    rdy_seen = bus.o_ready;
    chk("ready", bus.o_ready, rdy);
    @(posedge clk);
    model_edge(c, fire);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    logic r;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_b_taken", bus.o_b_taken, 0);
    chk("rst_pc", bus.o_pc, 0);
    chk("rst_rs_1", bus.o_rs_1, 0);
    chk("rst_rs_2", bus.o_rs_2, 0);
    chk("rst_rd_num", bus.o_rd_num, 0);
    chk("rst_opcode", bus.o_opcode, 0);
    chk("rst_func_3", bus.o_func_3, 0);
    chk("rst_func_7", bus.o_func_7, 0);
    chk("rst_imm", bus.o_imm, 0);
    chk("rst_b_pc", bus.o_b_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), r);
    chk("rst_ready", r, 1);
  endtask

  function automatic in_t rnd_in();
    in_t c;
    c.valid    = $urandom_range(0, 3) != 0;
    c.inst     = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  3'($urandom), 5'($urandom), ops[$urandom_range(0, 9)]};
    c.pc       = $urandom & 32'hFFFFFFFC;
    c.wb_en    = $urandom_range(0, 1) == 1;
    c.wb_rd    = 5'($urandom_range(0, 7));
    c.wb_d     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
    c.ex_load  = $urandom_range(0, 3) == 0;
    c.ex_rd    = 5'($urandom_range(0, 7));
    c.ex_ready = $urandom_range(0, 9) < 7;
    return c;
  endfunction

  initial begin
    vec_t vt [14];
    logic r;
    // inputs ..., ready, valid, rs_1, imm, rd, b_taken, b_pc
    vt[0]  = '{mk(0, 32'h0, 32'h0, 1, 5, 32'h1234, 0, 0, 1),          1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{mk(1, 32'h00128313, 32'h100, 0, 0, 0, 0, 0, 1),        1, 1, 32'h1234, 1, 6, 0, 0};
    vt[2]  = '{mk(1, 32'h001283B3, 32'h104, 0, 0, 0, 1, 5, 1),        0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{mk(1, 32'h001283B3, 32'h104, 0, 0, 0, 0, 0, 1),        1, 1, 32'h1234, 0, 7, 0, 0};
    vt[4]  = '{mk(1, 32'h00000863, 32'h200, 0, 0, 0, 0, 0, 1),        1, 1, 0, 16, 16, 1, 32'h210};
    vt[5]  = '{mk(1, 32'h00128313, 32'h204, 0, 0, 0, 0, 0, 1),        1, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{mk(0, 32'h0, 32'h0, 1, 2, 32'h303, 0, 0, 1),           1, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{mk(1, 32'h008100E7, 32'h300, 0, 0, 0, 0, 0, 0),        1, 1, 32'h303, 8, 1, 1, 32'h30A};
    vt[8]  = '{mk(1, 32'h00128313, 32'h304, 0, 0, 0, 0, 0, 0),        0, 1, 32'h303, 8, 1, 0, 0};
    vt[9]  = vt[8];
    vt[10] = vt[8];
    vt[11] = '{mk(1, 32'h00128313, 32'h304, 0, 0, 0, 0, 0, 1),        1, 0, 0, 0, 0, 0, 0};
    vt[12] = '{mk(1, 32'h00128313, 32'h304, 0, 0, 0, 0, 0, 1),        1, 1, 32'h1234, 1, 6, 0, 0};
    vt[13] = '{mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1),                 1, 0, 0, 0, 0, 0, 0};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].c, r);
      chk($sformatf("tbl%0d_ready", i), r, vt[i].e_ready);
      chk($sformatf("tbl%0d_valid", i), bus.o_valid, vt[i].e_valid);
      chk($sformatf("tbl%0d_b_taken", i), bus.o_b_taken, vt[i].e_bt);
      if (vt[i].e_valid) begin
        chk($sformatf("tbl%0d_rs_1", i), bus.o_rs_1, vt[i].e_rs1);
        chk($sformatf("tbl%0d_imm", i), bus.o_imm, vt[i].e_imm);
        chk($sformatf("tbl%0d_rd_num", i), bus.o_rd_num, vt[i].e_rd);
      end
      if (vt[i].e_bt) chk($sformatf("tbl%0d_b_pc", i), bus.o_b_pc, vt[i].e_bpc);
    end

    // Same-cycle write-back of x3 while decoding ADD x8,x3,x0
    cycle(mk(1, 32'h00018433, 32'h500, 1, 3, 32'hAA, 0, 0, 1), r);
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_ready", r, 1);
    chk("byp_valid", bus.o_valid, 1);
    chk("byp_rs_1", bus.o_rs_1, 32'hAA);
`else
    chk("wbstall_ready", r, 0);
    chk("wbstall_valid", bus.o_valid, 0);
    cycle(mk(1, 32'h00018433, 32'h500, 0, 0, 0, 0, 0, 1), r);
    chk("wbstall_ready2", r, 1);
    chk("wbstall_valid2", bus.o_valid, 1);
    chk("wbstall_rs_1", bus.o_rs_1, 32'hAA);
`endif
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), r);

    // Reset while squashing behind JAL x0,+8: next instruction must be accepted, x5 back to 0
    cycle(mk(1, 32'h0080006F, 32'h600, 0, 0, 0, 0, 0, 1), r);
    chk("jal_b_taken", bus.o_b_taken, 1);
    chk("jal_b_pc", bus.o_b_pc, 32'h608);
    do_reset();
    cycle(mk(1, 32'h00128313, 32'h604, 0, 0, 0, 0, 0, 1), r);
    chk("post_rst_valid", bus.o_valid, 1);
    chk("post_rst_rs_1", bus.o_rs_1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(rnd_in(), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
